// File: rtl/vga_pkg.sv
// rtl/vga_pkg.sv - shared VGA 640x480@60 timing and map window constants
package vga_pkg;

    typedef logic [9:0] coord_t;

    localparam int VGA_CLK_DIV       = 4;
    localparam int VGA_H_DISPLAY     = 640;
    localparam int VGA_H_FRONT       = 16;
    localparam int VGA_H_SYNC        = 96;
    localparam int VGA_H_BACK        = 48;
    localparam int VGA_V_DISPLAY     = 480;
    localparam int VGA_V_FRONT       = 10;
    localparam int VGA_V_SYNC        = 2;
    localparam int VGA_V_BACK        = 33;
    localparam bit VGA_SYNC_ACTIVE   = 1'b0;

    localparam int VGA_H_TOTAL = VGA_H_DISPLAY + VGA_H_FRONT + VGA_H_SYNC + VGA_H_BACK;
    localparam int VGA_V_TOTAL = VGA_V_DISPLAY + VGA_V_FRONT + VGA_V_SYNC + VGA_V_BACK;

    localparam int VGA_MAP_ORIGIN_X  = 270;
    localparam int VGA_MAP_ORIGIN_Y  = 190;
    localparam int VGA_MAP_WIDTH_X   = 100;
    localparam int VGA_MAP_WIDTH_Y   = 100;

    function automatic logic in_span(input coord_t v, input coord_t lo, input coord_t hi);
        return (v >= lo) && (v <= hi);
    endfunction

endpackage

// File: rtl/vga_scan_gen_if.sv
// rtl/vga_scan_gen_if.sv - scan position, sync and map window bundle
interface vga_scan_gen_if;
    import vga_pkg::*;

    logic   hsync;
    logic   vsync;
    logic   video_on;
    coord_t pixel_x;
    coord_t pixel_y;
    coord_t map_x;
    coord_t map_y;
    logic   map_on;
    logic   pixel_tick;
    logic   frame_start;

    modport master (
        output hsync, vsync, video_on, pixel_x, pixel_y,
               map_x, map_y, map_on, pixel_tick, frame_start
    );

    modport slave (
        input  hsync, vsync, video_on, pixel_x, pixel_y,
               map_x, map_y, map_on, pixel_tick, frame_start
    );
endinterface

// File: rtl/scan_counter.sv
// rtl/scan_counter.sv - modulo counter with enable and wrap strobe
module scan_counter
    import vga_pkg::*;
#(
    parameter int MODULUS = 800
) (
    input  logic   clk,
    input  logic   rst,
    input  logic   en_i,
    output coord_t cnt_o,
    output logic   wrap_o
);
    localparam coord_t LAST = coord_t'(MODULUS - 1);

    coord_t cnt_q, cnt_d;

    assign wrap_o = en_i && (cnt_q == LAST);
    assign cnt_o  = cnt_q;

    always_comb begin
        cnt_d = cnt_q;
        if (en_i) begin
            cnt_d = (cnt_q == LAST) ? '0 : cnt_q + coord_t'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) cnt_q <= '0;
        else     cnt_q <= cnt_d;
    end
endmodule

// File: rtl/vga_scan_gen.sv
// rtl/vga_scan_gen.sv - VGA timing and map-local raster position generator
module vga_scan_gen
    import vga_pkg::*;
#(
    parameter int CLK_DIV      = VGA_CLK_DIV,
    parameter int H_DISPLAY    = VGA_H_DISPLAY,
    parameter int H_FRONT      = VGA_H_FRONT,
    parameter int H_SYNC       = VGA_H_SYNC,
    parameter int H_BACK       = VGA_H_BACK,
    parameter int V_DISPLAY    = VGA_V_DISPLAY,
    parameter int V_FRONT      = VGA_V_FRONT,
    parameter int V_SYNC       = VGA_V_SYNC,
    parameter int V_BACK       = VGA_V_BACK,
    parameter bit SYNC_ACTIVE  = VGA_SYNC_ACTIVE,
    parameter int MAP_ORIGIN_X = VGA_MAP_ORIGIN_X,
    parameter int MAP_ORIGIN_Y = VGA_MAP_ORIGIN_Y,
    parameter int MAP_WIDTH_X  = VGA_MAP_WIDTH_X,
    parameter int MAP_WIDTH_Y  = VGA_MAP_WIDTH_Y
) (
    input  logic           clk,
    input  logic           rst,
    vga_scan_gen_if.master scan
);
    localparam int H_TOTAL = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;
    localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    if (CLK_DIV < 1 || H_TOTAL > 1024 || V_TOTAL > 1024 ||
        MAP_WIDTH_X < 1 || MAP_WIDTH_Y < 1 ||
        MAP_ORIGIN_X + MAP_WIDTH_X > H_DISPLAY ||
        MAP_ORIGIN_Y + MAP_WIDTH_Y > V_DISPLAY) begin : g_bad_params
        $error("vga_scan_gen: illegal timing or map window parameters");
    end

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam coord_t H_DISP_C = coord_t'(H_DISPLAY);
    localparam coord_t V_DISP_C = coord_t'(V_DISPLAY);
    localparam coord_t HS_LO    = coord_t'(H_DISPLAY + H_FRONT);
    localparam coord_t HS_HI    = coord_t'(H_DISPLAY + H_FRONT + H_SYNC - 1);
    localparam coord_t VS_LO    = coord_t'(V_DISPLAY + V_FRONT);
    localparam coord_t VS_HI    = coord_t'(V_DISPLAY + V_FRONT + V_SYNC - 1);
    localparam coord_t MX_LO    = coord_t'(MAP_ORIGIN_X);
    localparam coord_t MX_HI    = coord_t'(MAP_ORIGIN_X + MAP_WIDTH_X - 1);
    localparam coord_t MY_LO    = coord_t'(MAP_ORIGIN_Y);
    localparam coord_t MY_HI    = coord_t'(MAP_ORIGIN_Y + MAP_WIDTH_Y - 1);

    logic [DIV_W-1:0] div_q, div_d;
    logic             tick;
    coord_t           h_cnt, v_cnt;
    logic             h_wrap, v_wrap_unused;

    assign tick  = (div_q == DIV_LAST);
    assign div_d = tick ? '0 : div_q + DIV_W'(1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) div_q <= '0;
        else     div_q <= div_d;
    end

    scan_counter #(.MODULUS(H_TOTAL)) u_h_cnt (
        .clk(clk), .rst(rst), .en_i(tick), .cnt_o(h_cnt), .wrap_o(h_wrap)
    );

    scan_counter #(.MODULUS(V_TOTAL)) u_v_cnt (
        .clk(clk), .rst(rst), .en_i(h_wrap), .cnt_o(v_cnt), .wrap_o(v_wrap_unused)
    );

    logic   hsync_d, vsync_d, video_d, map_on_d, tick_d, fs_d;
    coord_t map_x_d, map_y_d;
    logic   hsync_q, vsync_q, video_q, map_on_q, tick_q, fs_q;
    coord_t px_q, py_q, map_x_q, map_y_q;

    // map_y counts upward from the window's bottom row
    always_comb begin
        video_d  = (h_cnt < H_DISP_C) && (v_cnt < V_DISP_C);
        hsync_d  = in_span(h_cnt, HS_LO, HS_HI) ? SYNC_ACTIVE : ~SYNC_ACTIVE;
        vsync_d  = in_span(v_cnt, VS_LO, VS_HI) ? SYNC_ACTIVE : ~SYNC_ACTIVE;
        map_on_d = video_d && in_span(h_cnt, MX_LO, MX_HI) && in_span(v_cnt, MY_LO, MY_HI);
        map_x_d  = map_on_d ? h_cnt - MX_LO : '0;
        map_y_d  = map_on_d ? MY_HI - v_cnt : '0;
        tick_d   = tick;
        fs_d     = (div_q == '0) && (h_cnt == '0) && (v_cnt == '0);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hsync_q  <= ~SYNC_ACTIVE;
            vsync_q  <= ~SYNC_ACTIVE;
            video_q  <= 1'b0;
            px_q     <= '0;
            py_q     <= '0;
            map_x_q  <= '0;
            map_y_q  <= '0;
            map_on_q <= 1'b0;
            tick_q   <= 1'b0;
            fs_q     <= 1'b0;
        end else begin
            hsync_q  <= hsync_d;
            vsync_q  <= vsync_d;
            video_q  <= video_d;
            px_q     <= h_cnt;
            py_q     <= v_cnt;
            map_x_q  <= map_x_d;
            map_y_q  <= map_y_d;
            map_on_q <= map_on_d;
            tick_q   <= tick_d;
            fs_q     <= fs_d;
        end
    end

    assign scan.hsync       = hsync_q;
    assign scan.vsync       = vsync_q;
    assign scan.video_on    = video_q;
    assign scan.pixel_x     = px_q;
    assign scan.pixel_y     = py_q;
    assign scan.map_x       = map_x_q;
    assign scan.map_y       = map_y_q;
    assign scan.map_on      = map_on_q;
    assign scan.pixel_tick  = tick_q;
    assign scan.frame_start = fs_q;
endmodule

// File: tb/tb_vga_scan_gen.sv
// tb/tb_vga_scan_gen.sv - scoreboard bench for vga_scan_gen on a reduced raster
module tb_vga_scan_gen;
    localparam int D   = 3;
    localparam int HD  = 20, HF = 2, HS = 3, HB = 3;
    localparam int VD  = 12, VF = 2, VS = 2, VB = 2;
    localparam int HT  = HD + HF + HS + HB;
    localparam int VT  = VD + VF + VS + VB;
    localparam bit SA  = 1'b0;
    localparam int MOX = 5, MOY = 4, MWX = 8, MWY = 6;
    localparam int FRAME  = D * HT * VT;
    localparam int FRAME1 = HT * VT;

    typedef struct packed {
        logic       hs;
        logic       vs;
        logic       vid;
        logic [9:0] px;
        logic [9:0] py;
        logic [9:0] mx;
        logic [9:0] my;
        logic       mon;
        logic       tick;
        logic       fs;
    } obs_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic rst2 = 1'b1;
    always #5 clk = ~clk;

    vga_scan_gen_if sc1 ();
    vga_scan_gen_if sc2 ();

    vga_scan_gen #(
        .CLK_DIV(D), .H_DISPLAY(HD), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
        .V_DISPLAY(VD), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB), .SYNC_ACTIVE(SA),
        .MAP_ORIGIN_X(MOX), .MAP_ORIGIN_Y(MOY), .MAP_WIDTH_X(MWX), .MAP_WIDTH_Y(MWY)
    ) dut (.clk(clk), .rst(rst), .scan(sc1));

    vga_scan_gen #(
        .CLK_DIV(1), .H_DISPLAY(HD), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
        .V_DISPLAY(VD), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB), .SYNC_ACTIVE(SA),
        .MAP_ORIGIN_X(MOX), .MAP_ORIGIN_Y(MOY), .MAP_WIDTH_X(MWX), .MAP_WIDTH_Y(MWY)
    ) dut1 (.clk(clk), .rst(rst2), .scan(sc2));

    obs_t expq[$];
    int   checks = 0;
    int   errors = 0;
    int   ecnt = 0;
    int   n2 = 0;

    // n = clock edges seen since reset release; output shows the scan position of edge n-1
    function automatic obs_t model(input int n);
        obs_t o;
        int idx, dv, p, h, v;
        o    = '0;
        o.hs = ~SA;
        o.vs = ~SA;
        if (n == 0) return o;
        idx  = n - 1;
        dv   = idx % D;
        p    = idx / D;
        h    = p % HT;
        v    = (p / HT) % VT;
        o.vid  = (h < HD) && (v < VD);
        o.hs   = (h >= HD + HF && h < HD + HF + HS) ? SA : ~SA;
        o.vs   = (v >= VD + VF && v < VD + VF + VS) ? SA : ~SA;
        o.px   = 10'(h);
        o.py   = 10'(v);
        o.mon  = o.vid && h >= MOX && h < MOX + MWX && v >= MOY && v < MOY + MWY;
        if (o.mon) begin
            o.mx = 10'(h - MOX);
            o.my = 10'(MOY + MWY - 1 - v);
        end
        o.tick = (dv == D - 1);
        o.fs   = (idx % FRAME) == 0;
        return o;
    endfunction

    function automatic obs_t sample1();
        obs_t a;
        a.hs = sc1.hsync;   a.vs = sc1.vsync;     a.vid = sc1.video_on;
        a.px = sc1.pixel_x; a.py = sc1.pixel_y;
        a.mx = sc1.map_x;   a.my = sc1.map_y;     a.mon = sc1.map_on;
        a.tick = sc1.pixel_tick; a.fs = sc1.frame_start;
        return a;
    endfunction

    initial begin
        forever begin
            @(posedge clk);
            ecnt = rst ? 0 : ecnt + 1;
            n2   = rst2 ? 0 : n2 + 1;
            expq.push_back(model(ecnt));
        end
    end

    initial begin
        obs_t e, a;
        forever begin
            @(negedge clk);
            checks++;
            if (expq.size() == 0) begin
                errors++;
                $display("FAIL scoreboard_empty t=%0t act=empty exp=entry", $time);
            end else begin
                e = expq.pop_front();
                a = sample1();
                if (a !== e) begin
                    errors++;
                    $display("FAIL scan_outputs t=%0t act=%h exp=%h (px=%0d py=%0d exp px=%0d py=%0d)",
                             $time, a, e, a.px, a.py, e.px, e.py);
                end
            end
            if (n2 > 0) begin
                checks++;
                if (sc2.pixel_tick !== 1'b1) begin
                    errors++;
                    $display("FAIL div1_pixel_tick t=%0t act=%b exp=1", $time, sc2.pixel_tick);
                end
            end
        end
    end

    task automatic measure_frames(input bit use2, input int frame, input string name);
        int cnt = 0, last = -1, seen = 0;
        while (seen < 3 && cnt < 4 * frame) begin
            @(negedge clk);
            cnt++;
            if ((use2 ? sc2.frame_start : sc1.frame_start) === 1'b1) begin
                if (last >= 0) begin
                    checks++;
                    if (cnt - last != frame) begin
                        errors++;
                        $display("FAIL %s act=%0d exp=%0d", name, cnt - last, frame);
                    end
                end
                last = cnt;
                seen++;
            end
        end
        if (seen < 3) begin
            checks++; errors++;
            $display("FAIL %s_timeout act=%0d pulses exp=3", name, seen);
        end
    endtask

    task automatic check_hsync_width();
        int guard = 0, low = 0;
        logic [9:0] x0;
        @(negedge clk);
        while (sc1.hsync !== 1'b1 && guard < FRAME) begin @(negedge clk); guard++; end
        while (sc1.hsync !== SA && guard < FRAME) begin @(negedge clk); guard++; end
        x0 = sc1.pixel_x;
        while (sc1.hsync === SA && guard < FRAME) begin low++; @(negedge clk); guard++; end
        checks += 2;
        if (guard >= FRAME) begin
            errors++;
            $display("FAIL hsync_timeout act=%0d exp<%0d", guard, FRAME);
        end else if (low != HS * D) begin
            errors++;
            $display("FAIL hsync_width act=%0d exp=%0d", low, HS * D);
        end
        if (x0 != 10'(HD + HF)) begin
            errors++;
            $display("FAIL hsync_start_x act=%0d exp=%0d", x0, HD + HF);
        end
    endtask

    task automatic pulse_reset(input int hold);
        #2 rst = 1'b1;
        #1;
        checks++;
        if (sample1() !== model(0)) begin
            errors++;
            $display("FAIL async_reset t=%0t act=%h exp=%h", $time, sample1(), model(0));
        end
        repeat (hold) @(negedge clk);
        #2 rst = 1'b0;
    endtask

    initial begin
        int guard;
        repeat (3) @(negedge clk);
        #2;
        rst  = 1'b0;
        rst2 = 1'b0;
        measure_frames(1'b0, FRAME, "frame_period");
        measure_frames(1'b1, FRAME1, "div1_frame_period");
        check_hsync_width();

        guard = 0;
        @(negedge clk);
        while (!(sc1.pixel_x == 10'd15 && sc1.pixel_y == 10'd9) && guard < 2 * FRAME) begin
            @(negedge clk);
            guard++;
        end
        checks++;
        if (guard >= 2 * FRAME) begin
            errors++;
            $display("FAIL wait_midline act=%0d exp<%0d", guard, 2 * FRAME);
        end
        pulse_reset(2);

        for (int r = 0; r < 6; r++) begin
            repeat ($urandom_range(50, 2000)) @(negedge clk);
            pulse_reset(int'($urandom_range(1, 4)));
        end

        repeat (2 * FRAME) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/vga_scan_gen.md
Name: vga_scan_gen

Overview:
- Generates VGA 640x480@60 timing and the raster scan position from the 100 MHz system clock.
- Feeds the map pixel renderer: drives map_x, map_y and map_on, which are map-local coordinates for a rectangular map window placed on screen.
- Also drives hsync, vsync and video_on to the VGA pins and the RGB mux, plus pixel_tick and frame_start for frame-synchronous logic.

Parameters:
- CLK_DIV, 4: system clocks per pixel; must be >= 1.
- H_DISPLAY, 640: visible pixels per line.
- H_FRONT, 16: horizontal front porch, in pixels.
- H_SYNC, 96: hsync pulse width, in pixels.
- H_BACK, 48: horizontal back porch, in pixels.
- V_DISPLAY, 480: visible lines per frame.
- V_FRONT, 10: vertical front porch, in lines.
- V_SYNC, 2: vsync pulse width, in lines.
- V_BACK, 33: vertical back porch, in lines.
- SYNC_ACTIVE, 0: sync pulse level; 0 means active-low.
- MAP_ORIGIN_X, 270: screen x of the map window's left column.
- MAP_ORIGIN_Y, 190: screen y of the map window's top row.
- MAP_WIDTH_X, 100: map window width, in pixels.
- MAP_WIDTH_Y, 100: map window height, in pixels.

Ports:
- clk  in  1  system clock; the only clock.
- rst  in  1  asynchronous, active-high reset.
- hsync  out  1  horizontal sync, registered.
- vsync  out  1  vertical sync, registered.
- video_on  out  1  high inside the 640x480 visible area.
- pixel_x  out  10  screen column, 0..H_TOTAL-1.
- pixel_y  out  10  screen line, 0..V_TOTAL-1.
- map_x  out  10  map-local column, 0 at the left edge of the window.
- map_y  out  10  map-local row, 0 at the bottom edge of the window (y axis points up).
- map_on  out  1  high when the scan position is inside the map window and video_on is high.
- pixel_tick  out  1  one-clk strobe on the last clk of each pixel period.
- frame_start  out  1  one-clk pulse on the first clk of pixel (0,0).

Behaviour:
- Derived constants: H_TOTAL = H_DISPLAY+H_FRONT+H_SYNC+H_BACK (800 at defaults); V_TOTAL = V_DISPLAY+V_FRONT+V_SYNC+V_BACK (525 at defaults).
- Elaboration error if the map window does not fit inside the display area, or if H_TOTAL or V_TOTAL exceeds 1024.
- Reset: rst is asynchronous and active-high and may assert at any time, including mid-frame. While rst is high:
  - div_cnt, h_cnt and v_cnt are 0.
  - hsync and vsync are at the inactive level (~SYNC_ACTIVE).
  - All other outputs are 0.
- Divider: div_cnt counts 0..CLK_DIV-1 and wraps. The internal tick condition is div_cnt == CLK_DIV-1; with CLK_DIV = 1 it is always true.
- Counters: on each tick:
  - h_cnt increments and wraps from H_TOTAL-1 to 0.
  - When h_cnt wraps, v_cnt increments and wraps from V_TOTAL-1 to 0.
  - h_cnt and v_cnt never leave these ranges.
- Outputs: all outputs are registered from the current values of div_cnt, h_cnt and v_cnt. This gives a fixed 1-clk latency from the state to the pins, identical for every output, so all outputs stay mutually aligned.
- video_on = (h_cnt < H_DISPLAY) && (v_cnt < V_DISPLAY).
- hsync = SYNC_ACTIVE when h_cnt is in [H_DISPLAY+H_FRONT, H_DISPLAY+H_FRONT+H_SYNC-1], otherwise ~SYNC_ACTIVE.
- vsync uses the same rule on v_cnt with the V_* parameters.
- Map window, inside = h_cnt in [MAP_ORIGIN_X, MAP_ORIGIN_X+MAP_WIDTH_X-1] and v_cnt in [MAP_ORIGIN_Y, MAP_ORIGIN_Y+MAP_WIDTH_Y-1].
  - map_on = inside && video_on.
  - map_x = h_cnt - MAP_ORIGIN_X.
  - map_y = MAP_ORIGIN_Y + MAP_WIDTH_Y - 1 - v_cnt.
  - When map_on is 0, map_x and map_y are forced to 0, so no wrapped values ever appear.
  - All arithmetic is 10-bit unsigned.
- pixel_tick = registered (div_cnt == CLK_DIV-1).
- frame_start = registered (div_cnt == 0 && h_cnt == 0 && v_cnt == 0), high for exactly 1 clk per frame.
  - The first frame begins at reset release, so frame_start pulses on the first clk edge after rst deasserts.
- Each output value is held for CLK_DIV clks.

Decomposition:
- Shared package vga_pkg holds:
  - the default VGA timing constants;
  - the derived totals H_TOTAL and V_TOTAL;
  - the map window origin and size constants.
  - The map renderer uses the same package.
- One natural sub-module: scan_counter, a parameterised modulo counter with enable and wrap output, instantiated twice (horizontal and vertical).
- The clock divider stays inline.

Test Plan:
- Release reset, count clks between frame_start pulses -> 800*525*4 = 1,680,000 clks; frame_start is high for exactly 1 clk each time.
- Measure hsync within one line -> low for 96*4 = 384 clks, starting at pixel_x = 656; vsync low exactly on pixel_y 490 and 491.
- Sample the map corners:
  - scan (270,289) -> map_on = 1, map (0,0);
  - scan (369,190) -> map (99,99);
  - scan (269,200) and (370,200) -> map_on = 0, map_x = map_y = 0.
- Scan (650,300) -> video_on = 0, map_on = 0, pixel_x = 650.
- Assert rst mid-line at pixel (400,250) -> all outputs reset immediately and asynchronously; after release, frame_start pulses next clk and the scan restarts at (0,0).
- Set CLK_DIV = 1 -> pixel_tick is constantly 1; the frame is 420,000 clks long.
